// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//
// Shared definitions for the multi-port register file (regfile_mp):
//   - default datapath width / depth constants
//   - clear-engine FSM state encoding
//   - depth helper used to size the array and the clear counter
//
// Optional build macro used by regfile_mp: REGFILE_BYPASS_EN
// -----------------------------------------------------------------------------
package regfile_pkg;

  // Default geometry of the MIPS datapath register file.
  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_N_RD   = 2;
  localparam int RF_DEPTH  = 1 << RF_ADDR_W;

  // Bulk-clear engine states.
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Number of entries addressed by an addr_w-bit address.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
//
// Bundles the write port, packed read ports and clear handshake of regfile_mp.
//
// Signals:
//   wr_en, wr_addr, wr_data : write request from writeback
//   wr_ready                : write accepted this cycle (low while clearing)
//   rd_addr                 : N_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data                 : N_RD packed read data,      port k at [k*DATA_W +: DATA_W]
//   clr_req                 : bulk-clear request (level)
//   clr_busy, clr_done      : clear in progress / one-cycle completion pulse
//
// Modports:
//   master : datapath side (decode / writeback / pipeline controller)
//   slave  : register file side
// -----------------------------------------------------------------------------
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int N_RD   = RF_N_RD
);

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ready;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, clr_req,
    input  wr_ready, rd_data, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
    output wr_ready, rd_data, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clr_fsm
//
// Sequential bulk-clear engine. From IDLE a high clr_req_i moves to CLEAR;
// in CLEAR one entry per cycle is zeroed, walking addresses 0..DEPTH-1.
// After the last entry the engine returns to IDLE and pulses clr_done_o for
// one cycle (same edge that drops clr_busy_o).
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset (aborts a clear, no done pulse)
//   clr_req_i    : clear request, only looked at in IDLE
//   clr_busy_o   : high while in CLEAR
//   clr_done_o   : one-cycle completion pulse
//   clr_we_o     : zero the entry at clr_addr_o on the next edge
//   clr_addr_o   : entry being cleared this cycle
// -----------------------------------------------------------------------------
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam int DEPTH = rf_depth(ADDR_W);

  // Counter carries one spare bit; the terminal compare stops it at DEPTH-1
  // so it never wraps past the array.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q,   cnt_d;
  logic              done_q,  done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    clr_we_o = 1'b0;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        // clr_req_i is deliberately ignored here.
        clr_we_o = 1'b1;
        if (cnt_q == LAST) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RF_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_busy_o = (state_q == RF_CLEAR);
  assign clr_done_o = done_q;
  assign clr_addr_o = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised register file for the MIPS datapath: one clocked write port,
// N_RD asynchronous read ports, a sequential bulk-clear engine and an
// optional same-cycle write-to-read bypass.
//
// Parameters:
//   DATA_W  : register width
//   ADDR_W  : address width, DEPTH = 2**ADDR_W
//   N_RD    : number of read ports (>= 1)
//   ZERO_R0 : 1 -> entry 0 always reads 0 and writes to it are dropped
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset; clears every entry and the engine
//   bus   : regfile_mp_if.slave (write port, read ports, clear handshake)
//
// Build option:
//   REGFILE_BYPASS_EN defined -> a read port addressing the entry being
//   written this cycle returns wr_data immediately (write-before-read).
//   Undefined -> the old value is seen until the write edge.
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int N_RD    = RF_N_RD,
  parameter int ZERO_R0 = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic                   clr_busy;
  logic                   clr_done;
  logic                   clr_we;
  logic [ADDR_W-1:0]      clr_addr;

  logic                   wr_ready;
  logic                   wr_fire;
  logic                   wr_zero;
  logic [N_RD*DATA_W-1:0] rd_mux;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (bus.clr_req),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Writes are refused for the whole clear, so the clear strobe and a real
  // write can never collide on the same edge.
  assign wr_ready = ~clr_busy;
  assign wr_fire  = bus.wr_en & wr_ready;
  assign wr_zero  = (ZERO_R0 != 0) && (bus.wr_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_fire && !wr_zero) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    rd_mux = '0;
    for (int k = 0; k < N_RD; k++) begin
      ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rv = mem_q[ra];
      if ((ZERO_R0 != 0) && (ra == '0)) begin
        rv = '0;
      end
`ifdef REGFILE_BYPASS_EN
      // wr_zero keeps the hard-wired zero entry from being bypassed.
      if (wr_fire && !wr_zero && (ra == bus.wr_addr)) begin
        rv = bus.wr_data;
      end
`endif
      rd_mux[k*DATA_W +: DATA_W] = rv;
    end
  end

  assign bus.rd_data  = rd_mux;
  assign bus.wr_ready = wr_ready;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Drives two register files in lockstep: one with ZERO_R0=0, one with
// ZERO_R0=1. A reference model predicts the visible outputs each cycle; the
// predictions go into a scoreboard queue and a monitor compares them against
// the DUTs on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 2;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra0, ra1;
  logic          cr;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) ifa ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) ifb ();

  assign ifa.wr_en   = we;
  assign ifa.wr_addr = wa;
  assign ifa.wr_data = wd;
  assign ifa.rd_addr = {ra1, ra0};
  assign ifa.clr_req = cr;
  assign ifb.wr_en   = we;
  assign ifb.wr_addr = wa;
  assign ifb.wr_data = wd;
  assign ifb.rd_addr = {ra1, ra0};
  assign ifb.clr_req = cr;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays plus "clear in progress / next entry".
  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] m1 [DEPTH];
  bit            active;
  int            idx;
  bit            done_m;

  typedef struct {
    int          dut;
    int          sig;
    int          port;
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic string sig_name(input int s);
    case (s)
      0:       return "rd_data";
      1:       return "wr_ready";
      2:       return "clr_busy";
      default: return "clr_done";
    endcase
  endfunction

  function automatic logic [15:0] exp_rd(input int z, input logic [AW-1:0] a);
    logic [15:0] v;
    v = (z == 1) ? m1[a] : m0[a];
    if (z == 1 && a == 0) v = '0;
`ifdef REGFILE_BYPASS_EN
    if (we && !active && a == wa && !(z == 1 && wa == 0)) v = wd;
`endif
    return v;
  endfunction

  function automatic logic [15:0] act(input int d, input int s, input int p);
    if (d == 0) begin
      case (s)
        0:       return (p == 0) ? ifa.rd_data[15:0] : ifa.rd_data[31:16];
        1:       return {15'd0, ifa.wr_ready};
        2:       return {15'd0, ifa.clr_busy};
        default: return {15'd0, ifa.clr_done};
      endcase
    end else begin
      case (s)
        0:       return (p == 0) ? ifb.rd_data[15:0] : ifb.rd_data[31:16];
        1:       return {15'd0, ifb.wr_ready};
        2:       return {15'd0, ifb.clr_busy};
        default: return {15'd0, ifb.clr_done};
      endcase
    end
  endfunction

  task automatic push(input int d, input int s, input int p, input logic [15:0] e);
    item_t it;
    it.dut  = d;
    it.sig  = s;
    it.port = p;
    it.exp  = e;
    sb.push_back(it);
  endtask

  task automatic push_cycle();
    for (int d = 0; d < 2; d++) begin
      push(d, 0, 0, exp_rd(d, ra0));
      push(d, 0, 1, exp_rd(d, ra1));
      push(d, 1, 0, {15'd0, !active});
      push(d, 2, 0, {15'd0, active});
      push(d, 3, 0, {15'd0, done_m});
    end
  endtask

  // Monitor: checks every queued prediction on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t       it;
      logic [15:0] a;
      it = sb.pop_front();
      a  = act(it.dut, it.sig, it.port);
      n_vec++;
      if (a !== it.exp) begin
        n_err++;
        $display("FAIL %s dut%0d port%0d t=%0t: got %h expected %h",
                 sig_name(it.sig), it.dut, it.port, $time, a, it.exp);
      end
    end
  end

  // Apply what the registers see on a rising edge with the current inputs.
  task automatic model_edge();
    if (active) begin
      m0[idx] = '0;
      m1[idx] = '0;
      if (idx == DEPTH - 1) begin
        active = 0;
        idx    = 0;
        done_m = 1;
      end else begin
        idx++;
        done_m = 0;
      end
    end else begin
      done_m = 0;
      if (we) begin
        m0[wa] = wd;
        if (wa != 0) m1[wa] = wd;
      end
      if (cr) begin
        active = 1;
        idx    = 0;
      end
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same point one cycle later.
  task automatic step(input logic we_i, input logic [AW-1:0] wa_i, input logic [DW-1:0] wd_i,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic cr_i);
    we  = we_i;
    wa  = wa_i;
    wd  = wd_i;
    ra0 = r0;
    ra1 = r1;
    cr  = cr_i;
    push_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    we    = 1'b0;
    cr    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    active = 0;
    idx    = 0;
    done_m = 0;
    #1;
    push_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra0 = '0; ra1 = '0; cr = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // All entries read zero after reset.
    for (int i = 0; i < DEPTH; i += 2) step(1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 1), 1'b0);

    // Back-to-back writes, then dual read.
    step(1'b1, 3'd1, 16'h000E, 3'd0, 3'd0, 1'b0);
    step(1'b1, 3'd2, 16'h0004, 3'd1, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 1'b0);

    // Write and read the same address in one cycle, then read it back.
    step(1'b1, 3'd3, 16'h0008, 3'd3, 3'd3, 1'b0);
    step(1'b0, 3'd0, 16'h0000, 3'd3, 3'd1, 1'b0);

    // ZERO_R0 behaviour: address 0 vs address 7.
    step(1'b1, 3'd0, 16'hABCD, 3'd0, 3'd7, 1'b0);
    step(1'b1, 3'd7, 16'hABCD, 3'd0, 3'd7, 1'b0);
    step(1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b0);

    // Fill with 0xFFFF, one-cycle clear request, writes attempted while busy.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 16'hFFFF, 3'(i), 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b1, 3'($urandom_range(0, 7)), 16'h1234, 3'(i), 3'($urandom_range(0, 7)), 1'b0);
    for (int i = 0; i < DEPTH; i += 2) step(1'b0, 3'd0, 16'h0000, 3'(i), 3'(i + 1), 1'b0);

    // Write and clear request in the same cycle; the write must land first.
    step(1'b1, 3'd5, 16'h5A5A, 3'd5, 3'd4, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 3'd0, 16'h0, 3'd5, 3'(i), 1'b0);

    // clr_req held high: clears restart back to back.
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 3), 1'b0);

    // Randomised traffic with occasional clear requests.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 5), 1'b0);

    // Reset in the middle of a clear, with the counter at 4.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 16'(16'h1100 + i), 3'(i), 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 3'd6, 3'd7, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'h0, 3'd5, 3'd7, 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i += 2) step(1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 1), 1'b0);
    step(1'b1, 3'd6, 16'h7777, 3'd6, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 3'd6, 3'd5, 1'b0);
    step(1'b0, 3'd0, 16'h0, 3'd1, 3'd2, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS datapath. It replaces the fixed 8×16 combinational file with one clocked write port and N asynchronous read ports. It adds a sequential bulk-clear engine and an optional same-cycle write-to-read bypass. It sits between decode (read addresses), writeback (write port) and the pipeline controller (clear handshake).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- N_RD, 2, number of read ports (≥1)
- ZERO_R0, 0, when 1 entry 0 reads as 0 and writes to it are dropped

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write accepted this cycle when high (= !clr_busy)
- rd_addr  in  N_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
- clr_req  in  1  start bulk clear (level, sampled in IDLE)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse on clear completion

## Operation
- Reset (rst_n low, asynchronous): all entries 0, FSM to IDLE, clear counter 0, clr_busy 0, clr_done 0, wr_ready 1. rd_data therefore reads 0 on every port.
- Write: on the rising edge with wr_en && wr_ready, entry[wr_addr] <= wr_data. wr_en while !wr_ready is dropped, not queued. With ZERO_R0=1, writes to address 0 are dropped silently.
- Read: rd_data[k] = entry[rd_addr[k]] combinationally, with no read enable. Any number of ports may read the same address. With ZERO_R0=1, address 0 always returns 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE and clr_req → CLEAR, counter = 0.
  - CLEAR: each cycle entry[counter] <= 0 and counter++.
  - When counter == DEPTH-1 is cleared → IDLE, clr_done pulses for 1 cycle, counter returns to 0.
  - clr_req while in CLEAR is ignored. clr_req held high after done restarts a clear on the next cycle.
- Reads during CLEAR return the live contents: entries already cleared read 0, the rest read their old values.
- Write and clear-start in the same cycle (IDLE, wr_en, clr_req): the write commits, then the clear begins next edge.
- Reset during CLEAR aborts immediately; there is no clr_done pulse.
- Address arithmetic: the counter is ADDR_W+1 bits internally and the terminal compare is against DEPTH-1. There is no wrap beyond DEPTH.

## Timing
- Write latency: 1 edge. Data is visible on rd_data after the edge without bypass, or in the same cycle with bypass (see Configuration).
- Read latency: 0 cycles, purely combinational from rd_addr and array state.
- Clear takes exactly DEPTH cycles from the first busy cycle. clr_busy rises the edge after clr_req is sampled and falls on the same edge clr_done rises.
- wr_ready is combinational from state and low for exactly DEPTH cycles per clear.

## Configuration
- REGFILE_BYPASS_EN:
  - Defined: if wr_en && wr_ready && rd_addr[k]==wr_addr (and not the ZERO_R0 address 0), rd_data[k] = wr_data in the same cycle. This gives write-before-read semantics for writeback → decode.
  - Undefined: rd_data shows the pre-write value until the edge.

## Structure
- Shared package regfile_pkg holds the FSM state enum (RF_IDLE, RF_CLEAR) and the default width/depth constants used by the datapath.
- One sub-module, regfile_clr_fsm, contains the state, counter, clr_busy, clr_done and the clear-address/strobe outputs. The array and read muxes stay in regfile_mp.

## Test plan
- Reset, then read all 8 addresses on both ports → all 0x0000, wr_ready=1, clr_busy=0.
- Write 0x000E to addr 1 and 0x0004 to addr 2 on consecutive edges, then rd_addr={1,2} → rd_data={0x000E,0x0004}.
- Bypass: wr_en with addr 3 and 0x0008 while rd_addr[0]=3 in the same cycle → 0x0008 with REGFILE_BYPASS_EN, 0x0000 without; both read 0x0008 after the edge.
- Fill all entries with 0xFFFF and pulse clr_req → clr_busy high for 8 cycles, entry i reads 0 from cycle i+1, clr_done pulses once, wr_en with 0x1234 during busy is dropped.
- ZERO_R0=1: write 0xABCD to addr 0 → reads 0x0000. Write to addr 7 → reads 0xABCD.
- Assert rst_n low mid-clear at counter 4 → all entries 0, clr_busy 0, no clr_done, and wr_ready 1 after release.
